// File: rtl/noc_net_iface.sv
// PE-side NoC interface: TX packetizer and RX depacketizer, independent FSMs.
// Define NI_STATS_EN to add saturating tx/rx packet and drop counters.
//   state   | meaning
//   TX_IDLE | waiting for a send request
//   TX_HEAD | head flit held on net_out
//   TX_BODY | streaming payload words, last one tagged tail
//   RX_IDLE | waiting for a head flit
//   RX_BODY | delivering payload words of an accepted packet
//   RX_DROP | discarding a misrouted/malformed packet up to its tail
module noc_net_iface #(
  parameter int FLIT_W  = 32,
  parameter int ID_W    = 4,
  parameter int NODE_ID = 1,
  parameter int LEN_W   = 4,
  parameter int MAX_LEN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_req_valid,
  output logic              tx_req_ready,
  input  logic [ID_W-1:0]   tx_dest,
  input  logic [LEN_W-1:0]  tx_len,
  input  logic              tx_data_valid,
  output logic              tx_data_ready,
  input  logic [FLIT_W-1:0] tx_data,
  output logic              tx_err,
  output logic              net_out_valid,
  input  logic              net_out_ready,
  output logic [FLIT_W+1:0] net_out_flit,
  input  logic              net_in_valid,
  output logic              net_in_ready,
  input  logic [FLIT_W+1:0] net_in_flit,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [FLIT_W-1:0] rx_data,
  output logic [ID_W-1:0]   rx_src,
  output logic              rx_last,
  output logic              rx_err
`ifdef NI_STATS_EN
  ,
  output logic [15:0]       tx_pkt_cnt,
  output logic [15:0]       rx_pkt_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  localparam logic [1:0] T_BODY  = 2'b00;
  localparam logic [1:0] T_HEAD  = 2'b01;
  localparam logic [1:0] T_TAIL  = 2'b10;
  localparam logic [1:0] T_HONLY = 2'b11;
  localparam logic [ID_W-1:0]  MY_ID   = ID_W'(NODE_ID);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam int PAD_W = FLIT_W - 2*ID_W - LEN_W;

  typedef enum logic [1:0] {TX_IDLE, TX_HEAD, TX_BODY} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_BODY, RX_DROP} rx_state_t;

  // ---------------- TX ----------------
  tx_state_t         tx_state, tx_state_d;
  logic [LEN_W-1:0]  tx_cnt, tx_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [FLIT_W+1:0] out_flit_q, out_flit_d;
  logic              tx_err_q, tx_err_d;
  logic              tx_pkt_done;
  logic              out_fire;
  logic              tx_bad;

  assign out_fire = out_valid_q && net_out_ready;
  assign tx_bad   = (tx_len > LEN_MAX) || (tx_dest == MY_ID) || (tx_dest == '0);

  always_comb begin
    tx_state_d    = tx_state;
    tx_cnt_d      = tx_cnt;
    out_valid_d   = out_valid_q;
    out_flit_d    = out_flit_q;
    tx_err_d      = 1'b0;
    tx_req_ready  = 1'b0;
    tx_data_ready = 1'b0;
    tx_pkt_done   = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_req_ready = 1'b1;
        if (tx_req_valid) begin
          if (tx_bad) begin
            tx_err_d = 1'b1;
          end else begin
            out_flit_d  = {(tx_len == '0) ? T_HONLY : T_HEAD, tx_dest, MY_ID, tx_len,
                           {PAD_W{1'b0}}};
            out_valid_d = 1'b1;
            tx_cnt_d    = tx_len;
            tx_state_d  = TX_HEAD;
          end
        end
      end
      TX_HEAD, TX_BODY: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          if (out_flit_q[FLIT_W+1:FLIT_W] == T_TAIL || out_flit_q[FLIT_W+1:FLIT_W] == T_HONLY) begin
            tx_state_d  = TX_IDLE;
            tx_pkt_done = 1'b1;
          end else begin
            tx_state_d = TX_BODY;
          end
        end
        // Payload may be taken while the head drains so words follow back-to-back.
        tx_data_ready = (tx_cnt != '0) && (!out_valid_q || net_out_ready);
        if (tx_data_valid && tx_data_ready) begin
          out_flit_d  = {(tx_cnt == LEN_W'(1)) ? T_TAIL : T_BODY, tx_data};
          out_valid_d = 1'b1;
          tx_cnt_d    = tx_cnt - LEN_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      tx_err_q    <= 1'b0;
    end else begin
      tx_state    <= tx_state_d;
      tx_cnt      <= tx_cnt_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      tx_err_q    <= tx_err_d;
    end
  end

  assign net_out_valid = out_valid_q;
  assign net_out_flit  = out_flit_q;
  assign tx_err        = tx_err_q;

  // ---------------- RX ----------------
  rx_state_t         rx_state, rx_state_d;
  logic [LEN_W-1:0]  rx_cnt, rx_cnt_d;
  logic [ID_W-1:0]   pkt_src, pkt_src_d;
  logic              rx_valid_q, rx_last_q, rx_err_q;
  logic [FLIT_W-1:0] rx_data_q;
  logic [ID_W-1:0]   rx_src_q;
  logic              rx_err_d, rx_load, rx_last_d, rx_pkt_done;
  logic              in_fire, in_is_head, head_bad;
  logic [1:0]        in_type;
  logic [ID_W-1:0]   in_dest, in_src;
  logic [LEN_W-1:0]  in_len;

  assign in_type    = net_in_flit[FLIT_W+1:FLIT_W];
  assign in_dest    = net_in_flit[FLIT_W-1 -: ID_W];
  assign in_src     = net_in_flit[FLIT_W-1-ID_W -: ID_W];
  assign in_len     = net_in_flit[FLIT_W-1-2*ID_W -: LEN_W];
  assign in_is_head = in_type[0];
  assign in_fire    = net_in_valid && net_in_ready;
  // A multi-flit head claiming zero payload cannot be framed, so it is dropped too.
  assign head_bad   = (in_dest != MY_ID) || (in_len > LEN_MAX) ||
                      (in_type == T_HEAD && in_len == '0);

  always_comb begin
    rx_state_d   = rx_state;
    rx_cnt_d     = rx_cnt;
    pkt_src_d    = pkt_src;
    rx_err_d     = 1'b0;
    rx_load      = 1'b0;
    rx_last_d    = 1'b0;
    rx_pkt_done  = 1'b0;
    net_in_ready = (rx_state == RX_BODY) ? (!rx_valid_q || rx_ready) : 1'b1;
    if (in_fire) begin
      if (in_is_head && rx_state != RX_DROP) begin
        if (rx_state == RX_BODY) rx_err_d = 1'b1;
        if (head_bad) begin
          rx_err_d   = 1'b1;
          rx_state_d = (in_type == T_HEAD) ? RX_DROP : RX_IDLE;
        end else if (in_type == T_HONLY) begin
          rx_pkt_done = 1'b1;
          rx_state_d  = RX_IDLE;
        end else begin
          pkt_src_d  = in_src;
          rx_cnt_d   = in_len;
          rx_state_d = RX_BODY;
        end
      end else begin
        case (rx_state)
          RX_IDLE: rx_err_d = 1'b1;
          RX_DROP: if (in_type == T_TAIL || in_type == T_HONLY) rx_state_d = RX_IDLE;
          RX_BODY: begin
            rx_load  = 1'b1;
            rx_cnt_d = rx_cnt - LEN_W'(1);
            if (in_type == T_TAIL || rx_cnt == LEN_W'(1)) begin
              rx_last_d  = 1'b1;
              rx_state_d = RX_IDLE;
              if (in_type == T_TAIL && rx_cnt == LEN_W'(1)) rx_pkt_done = 1'b1;
              else                                         rx_err_d    = 1'b1;
            end
          end
          default: rx_state_d = RX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      pkt_src    <= '0;
      rx_valid_q <= 1'b0;
      rx_last_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_src_q   <= '0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      pkt_src  <= pkt_src_d;
      rx_err_q <= rx_err_d;
      if (rx_load) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= net_in_flit[FLIT_W-1:0];
        rx_last_q  <= rx_last_d;
        rx_src_q   <= pkt_src;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
        rx_last_q  <= 1'b0;
      end
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_src   = rx_src_q;
  assign rx_last  = rx_last_q;
  assign rx_err   = rx_err_q;

`ifdef NI_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_pkt_cnt <= '0;
      rx_pkt_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (tx_pkt_done && tx_pkt_cnt != 16'hFFFF) tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
      if (rx_pkt_done && rx_pkt_cnt != 16'hFFFF) rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
      if (rx_err_d    && drop_cnt   != 16'hFFFF) drop_cnt   <= drop_cnt + 16'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = tx_pkt_done ^ rx_pkt_done;
`endif

endmodule

// File: tb/tb_noc_net_iface.sv
// Directed bench for noc_net_iface: cycle-exact TX checks, handshake-driven RX checks.
module tb_noc_net_iface;
  logic        clk = 1'b0;
  logic        reset;
  logic        tx_req_valid, tx_req_ready;
  logic [3:0]  tx_dest;
  logic [3:0]  tx_len;
  logic        tx_data_valid, tx_data_ready;
  logic [31:0] tx_data;
  logic        tx_err;
  logic        net_out_valid, net_out_ready;
  logic [33:0] net_out_flit;
  logic        net_in_valid, net_in_ready;
  logic [33:0] net_in_flit;
  logic        rx_valid, rx_ready;
  logic [31:0] rx_data;
  logic [3:0]  rx_src;
  logic        rx_last, rx_err;
`ifdef NI_STATS_EN
  logic [15:0] tx_pkt_cnt, rx_pkt_cnt, drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [33:0] inj_q[$];
  logic [36:0] exp_q[$];
  logic        rdy_pat[$];

  noc_net_iface dut (
    .clk(clk), .reset(reset),
    .tx_req_valid(tx_req_valid), .tx_req_ready(tx_req_ready),
    .tx_dest(tx_dest), .tx_len(tx_len),
    .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready), .tx_data(tx_data),
    .tx_err(tx_err),
    .net_out_valid(net_out_valid), .net_out_ready(net_out_ready), .net_out_flit(net_out_flit),
    .net_in_valid(net_in_valid), .net_in_ready(net_in_ready), .net_in_flit(net_in_flit),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_src(rx_src),
    .rx_last(rx_last), .rx_err(rx_err)
`ifdef NI_STATS_EN
    , .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Feeds inj_q into net_in under valid/ready, drains rx with rdy_pat, scores against exp_q.
  task automatic rx_run(input string name, input int n_cycles, input int exp_errs);
    int idx, got, errs;
    logic fire, take;
    idx = 0; got = 0; errs = 0;
    for (int c = 0; c < n_cycles; c++) begin
      rx_ready     = rdy_pat[c % rdy_pat.size()];
      net_in_valid = (idx < inj_q.size());
      net_in_flit  = net_in_valid ? inj_q[idx] : 34'h0;
      #1;
      fire = net_in_valid && net_in_ready;
      take = rx_valid && rx_ready;
      if (rx_err) errs++;
      if (take) begin
        if (got < exp_q.size()) check({name, "_word"}, {27'h0, rx_last, rx_src, rx_data}, {27'h0, exp_q[got]});
        got++;
      end
      @(negedge clk);
      if (fire) idx++;
    end
    net_in_valid = 1'b0;
    rx_ready     = 1'b0;
    check({name, "_consumed"}, idx, inj_q.size());
    check({name, "_delivered"}, got, exp_q.size());
    check({name, "_errs"}, errs, exp_errs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tx_req_valid = 0; tx_dest = 0; tx_len = 0;
    tx_data_valid = 0; tx_data = 0; net_out_ready = 0;
    net_in_valid = 0; net_in_flit = 0; rx_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_tx_req_ready", tx_req_ready, 1);
    check("rst_net_in_ready", net_in_ready, 1);
    check("rst_net_out_valid", net_out_valid, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_errs", {tx_err, rx_err, tx_data_ready}, 0);
    reset = 1'b0;
    @(negedge clk);

    // TX: dest 5, len 3, words A B C, router always ready
    tx_req_valid = 1; tx_dest = 4'd5; tx_len = 4'd3; net_out_ready = 1;
    @(negedge clk);
    tx_req_valid = 0;
    check("tx_head_valid", net_out_valid, 1);
    check("tx_head_flit", net_out_flit, {2'b01, 32'h5130_0000});
    check("tx_req_busy", tx_req_ready, 0);
    check("tx_data_ready_head", tx_data_ready, 1);
    tx_data_valid = 1; tx_data = 32'hA000_000A;
    @(negedge clk);
    check("tx_word_a", net_out_flit, {2'b00, 32'hA000_000A});
    tx_data = 32'hB000_000B;
    @(negedge clk);
    check("tx_word_b", net_out_flit, {2'b00, 32'hB000_000B});
    tx_data = 32'hC000_000C;
    @(negedge clk);
    check("tx_tail_c", net_out_flit, {2'b10, 32'hC000_000C});
    check("tx_data_ready_done", tx_data_ready, 0);
    check("tx_req_busy_tail", tx_req_ready, 0);
    tx_data_valid = 0;
    @(negedge clk);
    check("tx_idle_valid", net_out_valid, 0);
    check("tx_idle_req_ready", tx_req_ready, 1);

    // TX rejects: len 9, dest == self, dest 0; then a head-only packet
    tx_req_valid = 1; tx_dest = 4'd5; tx_len = 4'd9;
    @(negedge clk);
    check("tx_err_len", {tx_err, net_out_valid, tx_req_ready}, 3'b101);
    tx_dest = 4'd1; tx_len = 4'd2;
    @(negedge clk);
    check("tx_err_self", {tx_err, net_out_valid}, 2'b10);
    tx_dest = 4'd0; tx_len = 4'd1;
    @(negedge clk);
    check("tx_err_zero", {tx_err, net_out_valid}, 2'b10);
    tx_dest = 4'd2; tx_len = 4'd0;
    @(negedge clk);
    tx_req_valid = 0;
    check("tx_ok_after_err", {tx_err, net_out_valid}, 2'b01);
    check("tx_honly_flit", net_out_flit, {2'b11, 32'h2100_0000});
    @(negedge clk);
    check("tx_honly_done", {net_out_valid, tx_req_ready}, 2'b01);

    // RX: good packet with PE stalls
    inj_q = '{{2'b01, 32'h1720_0000}, {2'b00, 32'hAAAA_0001}, {2'b10, 32'hBBBB_0002}};
    exp_q = '{{1'b0, 4'd7, 32'hAAAA_0001}, {1'b1, 4'd7, 32'hBBBB_0002}};
    rdy_pat = '{1'b1, 1'b0, 1'b1};
    rx_run("rx_good", 16, 0);

    // RX: misrouted packet dropped, next one delivered
    inj_q = '{{2'b01, 32'h3230_0000}, {2'b00, 32'h1111_1111}, {2'b00, 32'h2222_2222},
              {2'b10, 32'h3333_3333}, {2'b01, 32'h1410_0000}, {2'b10, 32'hCAFE_0001}};
    exp_q = '{{1'b1, 4'd4, 32'hCAFE_0001}};
    rdy_pat = '{1'b1};
    rx_run("rx_drop", 20, 1);

    // RX: early tail, then head-only (silent), then stray body in IDLE
    inj_q = '{{2'b01, 32'h1630_0000}, {2'b00, 32'hD00D_0001}, {2'b10, 32'hD00D_0002},
              {2'b11, 32'h1200_0000}, {2'b00, 32'hDEAD_BEEF}};
    exp_q = '{{1'b0, 4'd6, 32'hD00D_0001}, {1'b1, 4'd6, 32'hD00D_0002}};
    rdy_pat = '{1'b1};
    rx_run("rx_short", 20, 2);

    // RX: new head mid-packet truncates the old one and starts the new
    inj_q = '{{2'b01, 32'h1520_0000}, {2'b00, 32'h5555_0001},
              {2'b01, 32'h1310_0000}, {2'b10, 32'h3333_0002}};
    exp_q = '{{1'b0, 4'd5, 32'h5555_0001}, {1'b1, 4'd3, 32'h3333_0002}};
    rdy_pat = '{1'b1, 1'b1, 1'b0};
    rx_run("rx_rehead", 20, 1);

    // Reset mid-TX with router stalled
    net_out_ready = 0;
    tx_req_valid = 1; tx_dest = 4'd5; tx_len = 4'd2;
    @(negedge clk);
    tx_req_valid = 0;
    check("stall_head", net_out_flit, {2'b01, 32'h5120_0000});
    tx_data_valid = 1; tx_data = 32'hD1D1_D1D1;
    @(negedge clk);
    check("stall_head_held", {net_out_valid, net_out_flit}, {1'b1, 2'b01, 32'h5120_0000});
    check("stall_no_data_ready", tx_data_ready, 0);
    net_out_ready = 1;
    @(negedge clk);
    net_out_ready = 0; tx_data = 32'hD2D2_D2D2;
    check("stall_body", net_out_flit, {2'b00, 32'hD1D1_D1D1});
    @(negedge clk);
    check("stall_body_held", {net_out_valid, net_out_flit}, {1'b1, 2'b00, 32'hD1D1_D1D1});
`ifdef NI_STATS_EN
    check("stats_tx", tx_pkt_cnt, 2);
    check("stats_rx", rx_pkt_cnt, 4);
    check("stats_drop", drop_cnt, 4);
`endif
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", net_out_valid, 0);
    check("mid_rst_req_ready", tx_req_ready, 1);
    check("mid_rst_data_ready", tx_data_ready, 0);
`ifdef NI_STATS_EN
    check("mid_rst_stats", {tx_pkt_cnt, rx_pkt_cnt, drop_cnt}, 0);
`endif
    tx_data_valid = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {net_out_valid, tx_req_ready, net_in_ready}, 3'b011);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
